// File: rtl/pong_score_keeper_if.sv
// Signal bundle between the match controller and the rest of the game:
// start/ball position in, ball stage reset, scores and match status out.
interface pong_score_keeper_if;
  logic       start;
  logic [8:0] ball_y;
  logic       ball_reset;
  logic [3:0] score_1;
  logic [3:0] score_2;
  logic       point_1;
  logic       point_2;
  logic       game_over;
  logic [1:0] winner;
  // Debug view of the match state: 0 idle, 1 play, 2 serve, 3 game over.
  logic [1:0] fsm_state;

  modport master (
    output start, ball_y,
    input  ball_reset, score_1, score_2, point_1, point_2, game_over, winner, fsm_state
  );

  modport slave (
    input  start, ball_y,
    output ball_reset, score_1, score_2, point_1, point_2, game_over, winner, fsm_state
  );
endinterface

// File: rtl/pong_score_keeper.sv
// Match controller for pong: detects paddle-line misses, keeps scores and
// holds the ball stage in reset while a point is being re-served.
module pong_score_keeper #(
  parameter int SIZE        = 10,
  parameter int MIN_Y       = 10,
  parameter int MAX_Y       = 310,
  parameter int WIN_SCORE   = 9,
  parameter int SERVE_DELAY = 60
) (
  input logic               clock,
  input logic               reset,
  pong_score_keeper_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PLAY      = 2'd1,
    SERVE     = 2'd2,
    GAME_OVER = 2'd3
  } state_t;

  localparam logic [9:0]  SIZE_W = 10'(SIZE);
  localparam logic [9:0]  MIN_W  = 10'(MIN_Y);
  localparam logic [9:0]  MAX_W  = 10'(MAX_Y);
  localparam logic [3:0]  WIN_W  = 4'(WIN_SCORE);
  localparam logic [15:0] DLY_M1 = 16'(SERVE_DELAY - 1);

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic        ball_reset, ball_reset_n;
  logic [3:0]  score_1, score_1_n, score_2, score_2_n;
  logic        point_1, point_1_n, point_2, point_2_n;
  logic        game_over, game_over_n;
  logic [1:0]  winner, winner_n;

  logic [9:0]  pos;
  logic        miss_left, miss_right;
  logic [3:0]  score_1_inc, score_2_inc;

  // Right edge is computed one bit wider than ball_y so it cannot wrap.
  assign pos         = {1'b0, bus.ball_y};
  assign miss_left   = pos < MIN_W;
  assign miss_right  = (pos + SIZE_W) > MAX_W;
  assign score_1_inc = (score_1 == WIN_W) ? score_1 : score_1 + 4'd1;
  assign score_2_inc = (score_2 == WIN_W) ? score_2 : score_2 + 4'd1;

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    ball_reset_n = ball_reset;
    score_1_n    = score_1;
    score_2_n    = score_2;
    point_1_n    = 1'b0;
    point_2_n    = 1'b0;
    game_over_n  = game_over;
    winner_n     = winner;
    case (state)
      IDLE: begin
        ball_reset_n = 1'b1;
        if (bus.start) begin
          score_1_n    = 4'd0;
          score_2_n    = 4'd0;
          ball_reset_n = 1'b0;
          state_n      = PLAY;
        end
      end
      PLAY: begin
        ball_reset_n = 1'b0;
        // Left miss has priority when both lines are crossed at once.
        if (miss_left) begin
          score_2_n    = score_2_inc;
          point_2_n    = 1'b1;
          ball_reset_n = 1'b1;
          if (score_2_inc == WIN_W) begin
            state_n     = GAME_OVER;
            winner_n    = 2'b10;
            game_over_n = 1'b1;
          end else begin
            state_n = SERVE;
            cnt_n   = DLY_M1;
          end
        end else if (miss_right) begin
          score_1_n    = score_1_inc;
          point_1_n    = 1'b1;
          ball_reset_n = 1'b1;
          if (score_1_inc == WIN_W) begin
            state_n     = GAME_OVER;
            winner_n    = 2'b01;
            game_over_n = 1'b1;
          end else begin
            state_n = SERVE;
            cnt_n   = DLY_M1;
          end
        end
      end
      SERVE: begin
        ball_reset_n = 1'b1;
        if (cnt == 16'd0) begin
          ball_reset_n = 1'b0;
          state_n      = PLAY;
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      GAME_OVER: begin
        ball_reset_n = 1'b1;
        if (bus.start) begin
          score_1_n   = 4'd0;
          score_2_n   = 4'd0;
          winner_n    = 2'b00;
          game_over_n = 1'b0;
          state_n     = SERVE;
          cnt_n       = DLY_M1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 16'd0;
      ball_reset <= 1'b1;
      score_1    <= 4'd0;
      score_2    <= 4'd0;
      point_1    <= 1'b0;
      point_2    <= 1'b0;
      game_over  <= 1'b0;
      winner     <= 2'b00;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      ball_reset <= ball_reset_n;
      score_1    <= score_1_n;
      score_2    <= score_2_n;
      point_1    <= point_1_n;
      point_2    <= point_2_n;
      game_over  <= game_over_n;
      winner     <= winner_n;
    end
  end

  assign bus.ball_reset = ball_reset;
  assign bus.score_1    = score_1;
  assign bus.score_2    = score_2;
  assign bus.point_1    = point_1;
  assign bus.point_2    = point_2;
  assign bus.game_over  = game_over;
  assign bus.winner     = winner;
  assign bus.fsm_state  = state;

endmodule

// File: tb/tb_pong_score_keeper.sv
// Bench for pong_score_keeper: two instances (win at 9 and at 3) share the same
// stimulus and are checked every cycle against a match-level model.
module tb_pong_score_keeper;

  localparam int SIZE        = 10;
  localparam int MIN_Y       = 10;
  localparam int MAX_Y       = 310;
  localparam int SERVE_DELAY = 60;
  localparam int WINS [2]    = '{9, 3};

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [8:0] ball_y = 9'd150;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  pong_score_keeper_if bus0 ();
  pong_score_keeper_if bus1 ();

  assign bus0.start  = start;
  assign bus0.ball_y = ball_y;
  assign bus1.start  = start;
  assign bus1.ball_y = ball_y;

  pong_score_keeper #(.SIZE(SIZE), .MIN_Y(MIN_Y), .MAX_Y(MAX_Y),
                      .WIN_SCORE(9), .SERVE_DELAY(SERVE_DELAY))
    dut_w9 (.clock(clock), .reset(reset), .bus(bus0.slave));

  pong_score_keeper #(.SIZE(SIZE), .MIN_Y(MIN_Y), .MAX_Y(MAX_Y),
                      .WIN_SCORE(3), .SERVE_DELAY(SERVE_DELAY))
    dut_w3 (.clock(clock), .reset(reset), .bus(bus1.slave));

  logic       br [2];
  logic [3:0] s1 [2];
  logic [3:0] s2 [2];
  logic       p1 [2];
  logic       p2 [2];
  logic       go [2];
  logic [1:0] wn [2];

  assign br[0] = bus0.ball_reset;  assign br[1] = bus1.ball_reset;
  assign s1[0] = bus0.score_1;     assign s1[1] = bus1.score_1;
  assign s2[0] = bus0.score_2;     assign s2[1] = bus1.score_2;
  assign p1[0] = bus0.point_1;     assign p1[1] = bus1.point_1;
  assign p2[0] = bus0.point_2;     assign p2[1] = bus1.point_2;
  assign go[0] = bus0.game_over;   assign go[1] = bus1.game_over;
  assign wn[0] = bus0.winner;      assign wn[1] = bus1.winner;

  task automatic chk(input string name, input int inst, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s[w%0d] at %0t: got %0d expected %0d", name, WINS[inst], $time, act, exp);
    end
  endtask

  // Match-level model: a player "is active" while a match runs, and
  // serve_left is how many more cycles the ball stays held after a point.
  int m_s1 [2], m_s2 [2], m_win [2], m_left [2];
  bit m_p1 [2], m_p2 [2], m_active [2], m_over [2];

  always @(posedge clock or posedge reset) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_s1[i] <= 0; m_s2[i] <= 0; m_win[i] <= 0; m_left[i] <= 0;
        m_p1[i] <= 0; m_p2[i] <= 0; m_active[i] <= 0; m_over[i] <= 0;
      end else begin
        m_p1[i] <= 0;
        m_p2[i] <= 0;
        if (!m_active[i]) begin
          if (start) begin
            m_s1[i] <= 0; m_s2[i] <= 0; m_win[i] <= 0;
            m_over[i] <= 0; m_active[i] <= 1;
            m_left[i] <= m_over[i] ? SERVE_DELAY : 0;
          end
        end else if (m_left[i] > 0) begin
          m_left[i] <= m_left[i] - 1;
        end else if (int'(ball_y) < MIN_Y) begin
          m_p2[i] <= 1;
          m_s2[i] <= (m_s2[i] + 1 > WINS[i]) ? WINS[i] : m_s2[i] + 1;
          if (m_s2[i] + 1 >= WINS[i]) begin
            m_over[i] <= 1; m_win[i] <= 2; m_active[i] <= 0;
          end else begin
            m_left[i] <= SERVE_DELAY;
          end
        end else if (int'(ball_y) + SIZE > MAX_Y) begin
          m_p1[i] <= 1;
          m_s1[i] <= (m_s1[i] + 1 > WINS[i]) ? WINS[i] : m_s1[i] + 1;
          if (m_s1[i] + 1 >= WINS[i]) begin
            m_over[i] <= 1; m_win[i] <= 1; m_active[i] <= 0;
          end else begin
            m_left[i] <= SERVE_DELAY;
          end
        end
      end
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        chk("ball_reset", i, int'(br[i]), int'(!m_active[i] || m_left[i] > 0));
        chk("score_1",    i, int'(s1[i]), m_s1[i]);
        chk("score_2",    i, int'(s2[i]), m_s2[i]);
        chk("point_1",    i, int'(p1[i]), int'(m_p1[i]));
        chk("point_2",    i, int'(p2[i]), int'(m_p2[i]));
        chk("game_over",  i, int'(go[i]), int'(m_over[i]));
        chk("winner",     i, int'(wn[i]), m_win[i]);
      end
    end
  end

  // Counts consecutive cycles with ball_reset high, starting at the current
  // negedge; bounded so a stuck output still ends the run.
  task automatic count_high(input int inst, output int n);
    n = 0;
    for (int k = 0; k < 300; k++) begin
      if (!br[inst]) break;
      n++;
      @(negedge clock);
    end
  endtask

  task automatic miss(input logic [8:0] y);
    @(negedge clock);
    ball_y = y;
    @(negedge clock);
    ball_y = 9'd150;
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic reset_literals(input int inst);
    chk("rst_ball_reset", inst, int'(br[inst]), 1);
    chk("rst_score_1",    inst, int'(s1[inst]), 0);
    chk("rst_score_2",    inst, int'(s2[inst]), 0);
    chk("rst_point_1",    inst, int'(p1[inst]), 0);
    chk("rst_point_2",    inst, int'(p2[inst]), 0);
    chk("rst_game_over",  inst, int'(go[inst]), 0);
    chk("rst_winner",     inst, int'(wn[inst]), 0);
  endtask

  int n;

  initial begin
    #1 reset = 1'b1;
    #1 reset_literals(0);
    reset_literals(1);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    // Start from idle, then a long rally in mid-field with start re-pulsed.
    pulse_start();
    chk("play_ball_reset", 0, int'(br[0]), 0);
    repeat (50) @(negedge clock);
    pulse_start();
    repeat (50) @(negedge clock);
    chk("rally_score_2", 0, int'(s2[0]), 0);

    // Left miss at ball_y = 9.
    @(negedge clock);
    ball_y = 9'd9;
    @(negedge clock);
    ball_y = 9'd150;
    chk("left_score_2", 0, int'(s2[0]), 1);
    chk("left_point_2", 1, int'(p2[1]), 1);
    count_high(0, n);
    chk("serve_len", 0, n, SERVE_DELAY);

    // Right line boundary: 300 is safe, 301 is a miss; start ignored in serve.
    @(negedge clock);
    ball_y = 9'd300;
    repeat (5) @(negedge clock);
    chk("edge_300_score_1", 0, int'(s1[0]), 0);
    miss(9'd301);
    chk("right_score_1", 0, int'(s1[0]), 1);
    pulse_start();
    repeat (SERVE_DELAY + 2) @(negedge clock);

    miss(9'd400);
    repeat (SERVE_DELAY + 2) @(negedge clock);
    miss(9'd311);
    chk("w3_winner",     1, int'(wn[1]), 1);
    chk("w3_game_over",  1, int'(go[1]), 1);
    chk("w3_ball_reset", 1, int'(br[1]), 1);
    chk("w9_score_1",    0, int'(s1[0]), 3);

    // Game over (and serve) ignore misses.
    @(negedge clock);
    ball_y = 9'd0;
    repeat (10) @(negedge clock);
    ball_y = 9'd150;
    chk("frozen_score_2", 1, int'(s2[1]), 1);

    // Asynchronous reset mid-serve with score_1 = 3.
    @(negedge clock);
    chk("pre_rst_score_1", 0, int'(s1[0]), 3);
    #2 reset = 1'b1;
    #1 reset_literals(0);
    reset_literals(1);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Drive the w3 instance back into game over, then restart from there.
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      miss(9'd305);
      repeat (SERVE_DELAY + 2) @(negedge clock);
    end
    chk("w3_over_again", 1, int'(go[1]), 1);
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("restart_score_1",   1, int'(s1[1]), 0);
    chk("restart_winner",    1, int'(wn[1]), 0);
    chk("restart_game_over", 1, int'(go[1]), 0);
    count_high(1, n);
    chk("restart_serve_len", 1, n, SERVE_DELAY);
    repeat (10) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pong_score_keeper.md
Name: pong_score_keeper

Overview:
- Sits directly downstream of the ball stage. Consumes the ball's horizontal position `ball_y` and detects when the ball passes a paddle line.
- Keeps both players' scores and runs the match state machine: idle, play, serve delay, game over.
- Drives the ball stage's synchronous reset input (`ball_reset`) to re-serve the ball after every point.

Parameters:
- SIZE, 10, ball edge length in pixels; must match the ball stage.
- MIN_Y, 10, left paddle line (player 1); `ball_y < MIN_Y` is a miss by player 1.
- MAX_Y, 310, right paddle line (player 2); `ball_y + SIZE > MAX_Y` is a miss by player 2.
- WIN_SCORE, 9, points needed to win; range 1..15.
- SERVE_DELAY, 60, cycles `ball_reset` is held high between a point and the next serve; range 1..65535.

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  level or pulse; starts a match from IDLE or GAME_OVER.
- ball_y  input  9  ball horizontal position from the ball stage.
- ball_reset  output  1  registered; drives the ball stage's reset; high = ball held at start position.
- score_1  output  4  registered; player 1 score.
- score_2  output  4  registered; player 2 score.
- point_1  output  1  registered; one-cycle pulse when player 1 scores.
- point_2  output  1  registered; one-cycle pulse when player 2 scores.
- game_over  output  1  registered; high while in GAME_OVER.
- winner  output  2  registered; 00 = none, 01 = player 1, 10 = player 2.

Behaviour:
Reset (asynchronous, active-high, any time including mid-serve or mid-point):
- State = IDLE, delay counter = 0.
- `ball_reset` = 1, scores = 0, `point_1`/`point_2` = 0, `game_over` = 0, `winner` = 00.

States: IDLE, PLAY, SERVE, GAME_OVER (binary encoded, registered outputs).

IDLE:
- `ball_reset` = 1.
- `start` = 1 at an edge: scores cleared, state goes to PLAY, `ball_reset` = 0 after that edge.

PLAY:
- `ball_reset` = 0. `start` is ignored.
- Each edge compares `ball_y`: left miss if `ball_y < MIN_Y`; right miss if `{1'b0,ball_y} + SIZE > MAX_Y`, computed 10 bits wide with no wrap.
- If both conditions are true in one cycle, left miss wins. This is a degenerate case; with the defaults both conditions cannot hold together.
- On a left miss at edge N, after edge N:
  - `score_2` += 1, saturating at WIN_SCORE.
  - `point_2` = 1 for exactly one cycle.
  - `ball_reset` = 1.
- A right miss is symmetric: `score_1` += 1, `point_1` pulses.
- The ball stage therefore sees `ball_reset` at edge N+1.
- If the updated score equals WIN_SCORE: state goes to GAME_OVER; `winner` is set; `game_over` = 1 after edge N.
- Otherwise: state goes to SERVE and the counter loads SERVE_DELAY-1.

SERVE:
- `ball_reset` = 1; misses are not evaluated.
- The counter decrements each edge. When it reads 0, the next edge returns to PLAY.
- `ball_reset` is high for exactly SERVE_DELAY cycles.

GAME_OVER:
- `ball_reset` = 1; scores and `winner` are frozen.
- `start` = 1: scores cleared, `winner` = 00, `game_over` = 0, state goes to SERVE with a full delay.

Point pulses:
- Never both high at once.
- Never high outside the cycle after a detected miss.

Width rules:
- Scores are 4-bit.
- The counter is 16-bit; the unused upper bits stay 0.

Test Plan:
- Apply reset mid-run while in SERVE with `score_1` = 3 -> all outputs return to their reset values immediately, without waiting for a clock edge.
- Assert `start` in IDLE, hold `ball_y` = 150 for 100 cycles -> `ball_reset` = 0 one cycle after `start`; scores stay 0; no point pulses.
- In PLAY, drive `ball_y` = 9 for one cycle -> next cycle `score_2` = 1, `point_2` high for 1 cycle, `ball_reset` high for exactly 60 cycles, then 0.
- In PLAY, drive `ball_y` = 301 (301 + 10 > 310) -> `score_1` increments and `point_1` pulses. Drive `ball_y` = 300 -> no point.
- With WIN_SCORE = 3, give player 1 three right misses -> after the third: `winner` = 01, `game_over` = 1, `ball_reset` = 1; further `ball_y` = 0 produces no change.
- In GAME_OVER, assert `start` -> scores 0, `winner` = 00, `game_over` = 0, `ball_reset` high for SERVE_DELAY cycles, then PLAY. `start` asserted during PLAY or SERVE has no effect.
